// File: rtl/arp_pkg.sv
// Shared ARP constants and the request FSM state type.
package arp_pkg;

  localparam logic [15:0] ARP_OPER_REQUEST = 16'd1;
  localparam logic [15:0] ARP_OPER_REPLY   = 16'd2;
  localparam logic [15:0] ARP_HTYPE_ETH    = 16'd1;
  localparam logic [15:0] ARP_PTYPE_IPV4   = 16'h0800;
  localparam logic [47:0] MAC_BROADCAST    = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_RESP
  } req_state_t;

endpackage

// File: rtl/arp_retry_timer.sv
// Retransmission down-counter: expired rises load_value cycles after the load edge
// (the load cycle itself counts as the first cycle of the wait).
module arp_retry_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_value,
  output logic        expired
);

  logic [31:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value - 32'd1;
    end else if (count != 32'd0) begin
      count <= count - 32'd1;
    end
  end

  assign expired = (count == 32'd0);

endmodule

// File: rtl/arp_ctrl.sv
// ARP protocol controller: cache updates, replies for the local IP, and a single
// outstanding resolution request with timed retransmission.
module arp_ctrl
  import arp_pkg::*;
#(
  parameter int unsigned REQUEST_RETRY_COUNT = 4,
  parameter int unsigned REQUEST_TIMEOUT     = 125000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_frame_valid,
  output logic        s_frame_ready,
  input  logic [15:0] s_arp_htype,
  input  logic [15:0] s_arp_ptype,
  input  logic [15:0] s_arp_oper,
  input  logic [47:0] s_arp_sha,
  input  logic [31:0] s_arp_spa,
  input  logic [47:0] s_arp_tha,
  input  logic [31:0] s_arp_tpa,
  output logic        m_frame_valid,
  input  logic        m_frame_ready,
  output logic [47:0] m_eth_dest_mac,
  output logic [15:0] m_arp_oper,
  output logic [47:0] m_arp_tha,
  output logic [31:0] m_arp_tpa,
  output logic        m_cache_wr_valid,
  input  logic        m_cache_wr_ready,
  output logic [31:0] m_cache_wr_ip,
  output logic [47:0] m_cache_wr_mac,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_ip,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_error,
  output logic [47:0] resp_mac,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip
);

  localparam logic [31:0] TIMEOUT_VAL = 32'(REQUEST_TIMEOUT);
  localparam logic [31:0] RETRY_INIT  = 32'(REQUEST_RETRY_COUNT - 1);

  req_state_t  state;
  logic [31:0] target_ip;
  logic [31:0] retries;
  logic        reply_pending;
  logic [47:0] reply_mac;
  logic [31:0] reply_ip;
  logic        expired;

  logic        frame_accept, type_ok, cache_hit, reply_hit, match;
  logic        timeout, send_cand, reply_cand, out_free, grant_reply, grant_send;
  logic [47:0] reply_src_mac;
  logic [31:0] reply_src_ip;

  // The transmitter supplies SHA/SPA, and THA is irrelevant to the decisions here.
  logic unused_inputs;
  assign unused_inputs = ^{s_arp_tha, local_mac};

  assign s_frame_ready = !reply_pending && !m_cache_wr_valid;

  always_comb begin
    frame_accept = s_frame_valid && s_frame_ready;
    type_ok      = (s_arp_htype == ARP_HTYPE_ETH) && (s_arp_ptype == ARP_PTYPE_IPV4);
    cache_hit    = frame_accept && type_ok && (s_arp_spa != 32'd0) &&
                   ((s_arp_oper == ARP_OPER_REQUEST) || (s_arp_oper == ARP_OPER_REPLY));
    reply_hit    = frame_accept && type_ok && (s_arp_oper == ARP_OPER_REQUEST) &&
                   (s_arp_tpa == local_ip);
    match        = frame_accept && type_ok && (state == ST_WAIT) &&
                   (s_arp_oper == ARP_OPER_REPLY) && (s_arp_spa == target_ip);
    // An expiry with retries left competes for the output slot straight from WAIT.
    timeout      = (state == ST_WAIT) && expired && !match;
    send_cand    = (state == ST_SEND) || (timeout && (retries != 32'd0));
    reply_cand   = reply_pending || reply_hit;
    out_free     = !m_frame_valid || m_frame_ready;
    grant_reply  = out_free && reply_cand;
    grant_send   = out_free && !reply_cand && send_cand;
    reply_src_mac = reply_pending ? reply_mac : s_arp_sha;
    reply_src_ip  = reply_pending ? reply_ip  : s_arp_spa;
  end

  arp_retry_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (grant_send),
    .load_value (TIMEOUT_VAL),
    .expired    (expired)
  );

  // Output frame register, parked reply and cache write channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_frame_valid    <= 1'b0;
      m_eth_dest_mac   <= '0;
      m_arp_oper       <= '0;
      m_arp_tha        <= '0;
      m_arp_tpa        <= '0;
      reply_pending    <= 1'b0;
      reply_mac        <= '0;
      reply_ip         <= '0;
      m_cache_wr_valid <= 1'b0;
      m_cache_wr_ip    <= '0;
      m_cache_wr_mac   <= '0;
    end else begin
      if (grant_reply) begin
        m_frame_valid  <= 1'b1;
        m_eth_dest_mac <= reply_src_mac;
        m_arp_oper     <= ARP_OPER_REPLY;
        m_arp_tha      <= reply_src_mac;
        m_arp_tpa      <= reply_src_ip;
      end else if (grant_send) begin
        m_frame_valid  <= 1'b1;
        m_eth_dest_mac <= MAC_BROADCAST;
        m_arp_oper     <= ARP_OPER_REQUEST;
        m_arp_tha      <= '0;
        m_arp_tpa      <= target_ip;
      end else if (m_frame_ready) begin
        m_frame_valid  <= 1'b0;
      end

      if (reply_hit && !out_free) begin
        reply_pending <= 1'b1;
        reply_mac     <= s_arp_sha;
        reply_ip      <= s_arp_spa;
      end else if (reply_pending && out_free) begin
        reply_pending <= 1'b0;
      end

      if (cache_hit) begin
        m_cache_wr_valid <= 1'b1;
        m_cache_wr_ip    <= s_arp_spa;
        m_cache_wr_mac   <= s_arp_sha;
      end else if (m_cache_wr_ready) begin
        m_cache_wr_valid <= 1'b0;
      end
    end
  end

  // Request FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      target_ip  <= '0;
      retries    <= '0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_mac   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            target_ip <= req_ip;
            retries   <= RETRY_INIT;
            req_ready <= 1'b0;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (grant_send) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (match) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_mac   <= s_arp_sha;
          end else if (expired) begin
            if (retries != 32'd0) begin
              retries <= retries - 32'd1;
              state   <= grant_send ? ST_WAIT : ST_SEND;
            end else begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_mac   <= '0;
            end
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
